// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: frame timing constants and FSM encoding shared by the UART transmitter and receiver
package uart_tx_pkg;
  localparam int UART_BAUD_RATE = 19200;
  localparam int CLK_FREQ = 10_000_000;
  localparam int UART_DATA_LENGTH = 8;
  // Rounded to the nearest whole clock count: 10 MHz / 19200 baud gives 521
  localparam int BAUD_COUNTS_PER_BIT = (CLK_FREQ + UART_BAUD_RATE / 2) / UART_BAUD_RATE;
  localparam int TX_COUNTER_BITWIDTH = $clog2(UART_DATA_LENGTH);
  localparam int BAUD_RATE_COUNTER_BITWIDTH = $clog2(BAUD_COUNTS_PER_BIT);
  typedef enum logic [1:0] {
    stIDLE     = 2'd0,
    stSTARTBIT = 2'd1,
    stSENDING  = 2'd2,
    stSTOPBIT  = 2'd3
  } uart_state_e;
endpackage

// File: rtl/uart_tx_baud_counter.sv
// uart_tx_baud_counter: counts clock cycles within one line bit and flags the last cycle of each bit
module uart_tx_baud_counter #(
  parameter int COUNTS = uart_tx_pkg::BAUD_COUNTS_PER_BIT,
  parameter int WIDTH  = uart_tx_pkg::BAUD_RATE_COUNTER_BITWIDTH
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic bit_end_o
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(COUNTS - 1);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  assign bit_end_o = en_i && cnt_q == LAST;
  always_comb cnt_d = (clear_i || bit_end_o) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i)
    if (!reset_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises one byte per frame as start bit, LSB-first data bits and stop bit, no parity
module uart_tx import uart_tx_pkg::*; #(
  parameter int UART_DATA_LENGTH           = uart_tx_pkg::UART_DATA_LENGTH,
  parameter int TX_COUNTER_BITWIDTH        = uart_tx_pkg::TX_COUNTER_BITWIDTH,
  parameter int BAUD_COUNTS_PER_BIT        = uart_tx_pkg::BAUD_COUNTS_PER_BIT,
  parameter int BAUD_RATE_COUNTER_BITWIDTH = uart_tx_pkg::BAUD_RATE_COUNTER_BITWIDTH
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [UART_DATA_LENGTH-1:0] data_i,
  input  logic                        data_valid_i,
  output logic                        ready_o,
  output logic                        tx_o,
  output logic                        tx_done_strb_o
);
  localparam logic [TX_COUNTER_BITWIDTH-1:0] LAST_BIT = TX_COUNTER_BITWIDTH'(UART_DATA_LENGTH - 1);
  uart_state_e state_q, state_d;
  logic [UART_DATA_LENGTH-1:0] shift_q, shift_d;
  logic [TX_COUNTER_BITWIDTH-1:0] idx_q, idx_d;
  logic tx_q, tx_d;
  logic bit_end, accept, shift_en;
  assign accept = data_valid_i && ready_o;
  assign shift_en = state_q == stSENDING && bit_end;
  uart_tx_baud_counter #(
    .COUNTS(BAUD_COUNTS_PER_BIT),
    .WIDTH (BAUD_RATE_COUNTER_BITWIDTH)
  ) u_baud (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (state_q == stIDLE),
    .en_i     (state_q != stIDLE),
    .bit_end_o(bit_end)
  );
  always_ff @(posedge clk_i)
    if (!reset_i) state_q <= stIDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      stIDLE:     if (accept) state_d = stSTARTBIT;
      stSTARTBIT: if (bit_end) state_d = stSENDING;
      stSENDING:  if (bit_end && idx_q == LAST_BIT) state_d = stSTOPBIT;
      stSTOPBIT:  if (bit_end) state_d = stIDLE;
      default:    state_d = stIDLE;
    endcase
  end
  always_comb begin
    ready_o = state_q == stIDLE;
    tx_done_strb_o = state_q == stSTOPBIT && bit_end;
  end
  // Line level is derived from the next state so tx_o changes on the same edge as the state
  always_comb begin
    shift_d = accept ? data_i : shift_en ? shift_q >> 1 : shift_q;
    idx_d = (accept || (shift_en && idx_q == LAST_BIT)) ? '0 : shift_en ? idx_q + 1'b1 : idx_q;
    tx_d = state_d == stSTARTBIT ? 1'b0 : state_d == stSENDING ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge clk_i)
    if (!reset_i) begin
      shift_q <= '0;
      idx_q <= '0;
      tx_q <= 1'b1;
    end else begin
      shift_q <= shift_d;
      idx_q <= idx_d;
      tx_q <= tx_d;
    end
  assign tx_o = tx_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame-level checks of uart_tx line timing, handshake and reset behaviour
module tb_uart_tx;
  localparam int BPB = 521;
  logic clk = 1'b0;
  logic reset_i, data_valid_i, ready_o, tx_o, tx_done_strb_o;
  logic [7:0] data_i;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int f0, l0, f1, l1, sc, lc;

  uart_tx #(.BAUD_COUNTS_PER_BIT(BPB)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .data_i        (data_i),
    .data_valid_i  (data_valid_i),
    .ready_o       (ready_o),
    .tx_o          (tx_o),
    .tx_done_strb_o(tx_done_strb_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int j);
    return j == 0 ? 1'b0 : j == 9 ? 1'b1 : b[j-1];
  endfunction

  // Sends b, then drives hold_v/hold_d for the rest of the frame; returns the cycle of the
  // first low line sample and the cycle after the last low sample (the stop-bit start)
  task automatic frame(input logic [7:0] b, input logic hold_v, input logic [7:0] hold_d,
                       input string tag, output int first_low, output int stop_start);
    int bad[10];
    int rdy, strb, strb_at;
    logic [7:0] rx;
    bad = '{default: 0};
    rdy = 0; strb = 0; strb_at = -1; rx = '0;
    first_low = -1; stop_start = -1;
    data_i = b;
    data_valid_i = 1'b1;
    @(posedge clk); #1;
    data_valid_i = hold_v;
    data_i = hold_d;
    for (int e = 0; e < 10 * BPB; e++) begin
      int j = e / BPB;
      if (tx_o !== exp_bit(b, j)) bad[j]++;
      if (ready_o !== 1'b0) rdy++;
      if (tx_done_strb_o === 1'b1) begin strb++; strb_at = e; end
      if (tx_o === 1'b0) begin
        if (first_low < 0) first_low = cyc;
        stop_start = cyc + 1;
      end
      if (j >= 1 && j <= 8 && e % BPB == BPB / 2) rx[j-1] = tx_o;
      @(posedge clk); #1;
    end
    for (int j = 0; j < 10; j++) chk($sformatf("%s bit%0d wrong_cycles", tag, j), bad[j], 0);
    chk({tag, " ready_during_frame"}, rdy, 0);
    chk({tag, " done_count"}, strb, 1);
    chk({tag, " done_position"}, strb_at, 10 * BPB - 1);
    chk({tag, " decoded_byte"}, rx, b);
    chk({tag, " idle_tx"}, tx_o, 1'b1);
    chk({tag, " idle_ready"}, ready_o, 1'b1);
  endtask

  initial begin
    reset_i = 1'b0;
    data_valid_i = 1'b1;
    data_i = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("reset%0d tx", i), tx_o, 1'b1);
      chk($sformatf("reset%0d ready", i), ready_o, 1'b1);
      chk($sformatf("reset%0d done", i), tx_done_strb_o, 1'b0);
    end
    reset_i = 1'b1;
    data_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("post_reset tx", tx_o, 1'b1);
    chk("post_reset ready", ready_o, 1'b1);

    frame(8'hA5, 1'b0, 8'h5A, "a5", f0, l0);
    frame(8'h00, 1'b0, 8'hFF, "loop00", f0, l0);
    frame(8'hFF, 1'b0, 8'h00, "loopff", f0, l0);
    frame(8'h3C, 1'b0, 8'hC3, "loop3c", f0, l0);

    frame(8'h55, 1'b1, 8'h11, "busy55", f0, l0);
    frame(8'h11, 1'b0, 8'h00, "busy11", f1, l1);
    chk("busy gap", f1 - l0, BPB + 1);

    frame(8'h01, 1'b1, 8'h80, "b2b01", f0, l0);
    frame(8'h80, 1'b0, 8'h00, "b2b80", f1, l1);
    chk("b2b gap", f1 - l0, BPB + 1);

    data_i = 8'hF0;
    data_valid_i = 1'b1;
    @(posedge clk); #1;
    data_valid_i = 1'b0;
    data_i = 8'h00;
    repeat (4 * BPB + 100) begin @(posedge clk); #1; end
    chk("midreset pre tx", tx_o, 1'b0);
    chk("midreset pre ready", ready_o, 1'b0);
    reset_i = 1'b0;
    @(posedge clk); #1;
    chk("midreset tx", tx_o, 1'b1);
    chk("midreset ready", ready_o, 1'b1);
    chk("midreset done", tx_done_strb_o, 1'b0);
    reset_i = 1'b1;
    sc = 0; lc = 0;
    repeat (BPB + 100) begin
      @(posedge clk); #1;
      if (tx_done_strb_o === 1'b1) sc++;
      if (tx_o !== 1'b1) lc++;
    end
    chk("after_reset done_pulses", sc, 0);
    chk("after_reset line_not_idle", lc, 0);
    frame(8'hC3, 1'b0, 8'h3C, "c3", f0, l0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; serialises one byte per frame onto a single line: 1 start bit (0), UART_DATA_LENGTH data bits LSB first, 1 stop bit (1), no parity.
- Sits beside the existing UART receiver at the CPU's serial port. Sends bytes from the CPU/debug logic to the host.
- Uses the same baud parameters as the receiver so both ends run with identical frame timing.

Parameters:
- UART_BAUD_RATE, 19200, nominal baud rate (documentation only; timing comes from BAUD_COUNTS_PER_BIT)
- UART_DATA_LENGTH, 8, data bits per frame
- CLK_FREQ, 10000000, system clock in Hz (documentation only)
- TX_COUNTER_BITWIDTH, 3, width of the data-bit index counter; must hold UART_DATA_LENGTH-1
- BAUD_COUNTS_PER_BIT, 521, clock cycles per bit period
- BAUD_RATE_COUNTER_BITWIDTH, 10, width of the baud counter; must hold BAUD_COUNTS_PER_BIT-1

Ports:
- clk_i  input  1  system clock; all logic on the rising edge
- reset_i  input  1  synchronous, active-low reset
- data_i  input  UART_DATA_LENGTH  byte to transmit; sampled only on acceptance
- data_valid_i  input  1  requester has a byte ready
- ready_o  output  1  block can accept a byte this cycle
- tx_o  output  1  serial line; idles high
- tx_done_strb_o  output  1  one-cycle pulse at the end of each frame

Behaviour:
- Reset: reset_i=0 at a rising edge puts the block in stIDLE and clears the baud counter, bit counter and shift register. After that edge: tx_o=1, ready_o=1, tx_done_strb_o=0.
- Reset mid-frame: the frame is abandoned. tx_o=1 from the next edge; no done strobe is produced.
- States: stIDLE, stSTARTBIT, stSENDING, stSTOPBIT (2-bit encoding).
- stIDLE:
  - tx_o=1 and ready_o=1; ready_o is 0 in every other state.
  - A transfer is accepted when data_valid_i && ready_o at a rising edge. On that edge data_i is latched into the shift register, the baud counter is cleared and the state becomes stSTARTBIT.
  - Latency: tx_o goes to 0 in the cycle after acceptance.
- Baud counter:
  - Counts 0..BAUD_COUNTS_PER_BIT-1 in every non-idle state and is held at 0 in stIDLE.
  - bit_end = (baud counter == BAUD_COUNTS_PER_BIT-1). On bit_end the counter wraps to 0.
  - Each line bit therefore lasts exactly BAUD_COUNTS_PER_BIT cycles.
- stSTARTBIT: tx_o=0. On bit_end go to stSENDING with the bit index at 0.
- stSENDING:
  - tx_o = shift register bit 0.
  - On bit_end: shift right by one and increment the bit index.
  - On bit_end with bit index == UART_DATA_LENGTH-1: go to stSTOPBIT and clear the index.
- stSTOPBIT:
  - tx_o=1.
  - On bit_end go to stIDLE; tx_done_strb_o=1 in that same cycle only (combinational on state and bit_end).
- Frame length: (UART_DATA_LENGTH+2)*BAUD_COUNTS_PER_BIT cycles, measured from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back frames: after stop, at least one stIDLE cycle (the acceptance cycle), so tx_o stays high for at least BAUD_COUNTS_PER_BIT+1 cycles between frames.
- Input rules:
  - data_valid_i while ready_o=0 is ignored; the requester must hold it until accepted.
  - Changes on data_i after acceptance have no effect on the frame in progress.
- Output registering: tx_o is a register output (glitch-free line); ready_o is decoded from state.

Decomposition:
- Shared package/header: state encodings (stIDLE..stSTOPBIT) and the default baud constants (BAUD_COUNTS_PER_BIT, counter widths), so uart_rx and uart_tx stay consistent.
- Optional sub-module uart_baud_counter: clear/enable inputs, bit_end output. Reusable by uart_rx.
- Otherwise a single flat module.

Test Plan:
- Reset: hold reset_i=0 for 3 cycles, with data_valid_i=1 -> tx_o=1, ready_o=1, tx_done_strb_o=0, no frame starts while reset is held.
- Single byte 0xA5 (BAUD_COUNTS_PER_BIT=521):
  - tx_o=0 for 521 cycles, then bits 1,0,1,0,0,1,0,1 each for 521 cycles, then 1 for 521 cycles.
  - tx_done_strb_o is high exactly once, at cycle 5210 after acceptance.
- Loopback: drive tx_o into uart_rx with bytes 0x00, 0xFF, 0x3C -> receiver's data_o matches each byte and its valid strobe fires once per frame.
- Busy protection: assert data_valid_i with 0x11 during a frame of 0x55 -> ready_o=0, 0x55 is sent intact; 0x11 is accepted only in the next stIDLE cycle.
- Back-to-back: hold data_valid_i=1 with 0x01 then 0x80 -> the second start bit begins exactly BAUD_COUNTS_PER_BIT+1 cycles after the first stop bit starts.
- Mid-frame reset: pull reset_i=0 during data bit 3 -> tx_o=1 and ready_o=1 after the next edge, no done strobe; a subsequent 0xC3 frame transmits correctly.
